// File: rtl/mips_mc_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath/memory.
// The master side is the controller: it consumes instruction and status bits
// and drives every strobe and select.
interface mips_mc_ctrl_if;
  logic [31:0] instr;
  logic        alu_zero;
  logic        mem_ready;

  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic [3:0]  alu_op;
  logic        alu_a_sel;
  logic [1:0]  alu_b_sel;
  logic        cmp_unsigned;
  logic        sr_arith;
  logic        reg_we;
  logic [1:0]  reg_dst;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
  logic        illegal;
  logic        timeout;

  modport master (
    input  instr, alu_zero, mem_ready,
    output mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src,
           alu_op, alu_a_sel, alu_b_sel, cmp_unsigned, sr_arith,
           reg_we, reg_dst, wb_sel, state, illegal, timeout
  );

  modport slave (
    output instr, alu_zero, mem_ready,
    input  mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src,
           alu_op, alu_a_sel, alu_b_sel, cmp_unsigned, sr_arith,
           reg_we, reg_dst, wb_sel, state, illegal, timeout
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit. Only the state, the wait counter and the two
// sticky error flags are registered; every strobe and select is decoded
// combinationally from the current state and instruction.
//
//   state  | meaning
//   FETCH  | read instruction at PC, write IR and PC+4 when memory is ready
//   DECODE | jumps finish here; illegal encodings halt
//   EXEC   | ALU operation; branches resolve on alu_zero
//   MEM    | load/store access at the latched ALU result
//   WB     | register file write
//   HALT   | error stop, left only through reset
module mips_mc_ctrl #(
  parameter int TIMEOUT = 255
) (
  input logic            clk,
  input logic            rst,
  mips_mc_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_CMP = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_NOR = 4'd6;
  localparam logic [3:0] ALU_SL  = 4'd7;
  localparam logic [3:0] ALU_SR  = 4'd8;

  // Counter just wide enough to hold TIMEOUT; a zero TIMEOUT never compares.
  localparam int               CW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]    TO_VAL = CW'(TIMEOUT);

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic          r_illegal;
  logic          r_timeout;
  logic          w_set_illegal;
  logic          w_set_timeout;
  logic          w_waiting;
  logic          w_expired;

  logic [5:0]    w_op;
  logic [5:0]    w_fn;
  logic          w_is_rtype, w_is_jr, w_is_j, w_is_jal;
  logic          w_is_beq, w_is_bne, w_is_lw, w_is_sw, w_is_lui;

  logic          w_legal;
  logic [3:0]    w_dec_alu_op;
  logic          w_dec_a_sel;
  logic [1:0]    w_dec_b_sel;
  logic          w_dec_cmp_u;
  logic          w_dec_sr_ar;

  logic          w_mem_req, w_mem_we, w_addr_sel, w_ir_we, w_pc_we, w_reg_we;
  logic [1:0]    w_pc_src;
  logic [3:0]    w_alu_op;
  logic          w_alu_a_sel;
  logic [1:0]    w_alu_b_sel;
  logic          w_cmp_unsigned, w_sr_arith;
  logic [1:0]    w_reg_dst, w_wb_sel;

  // Register fields (rs/rt/rd/shamt/imm) are datapath business only.
  logic          w_unused_bits;
  assign w_unused_bits = ^bus.instr[25:6];

  assign w_op       = bus.instr[31:26];
  assign w_fn       = bus.instr[5:0];
  assign w_is_rtype = (w_op == OP_RTYPE);
  assign w_is_jr    = w_is_rtype && (w_fn == FN_JR);
  assign w_is_j     = (w_op == OP_J);
  assign w_is_jal   = (w_op == OP_JAL);
  assign w_is_beq   = (w_op == OP_BEQ);
  assign w_is_bne   = (w_op == OP_BNE);
  assign w_is_lw    = (w_op == OP_LW);
  assign w_is_sw    = (w_op == OP_SW);
  assign w_is_lui   = (w_op == OP_LUI);

  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_waiting  = ((r_state == S_FETCH) || (r_state == S_MEM)) && !bus.mem_ready;
  assign w_expired  = (TIMEOUT != 0) && (w_cnt_inc == TO_VAL);

  // Instruction decode: legality plus the ALU controls used in EXEC and WB.
  always_comb begin
    w_legal      = 1'b1;
    w_dec_alu_op = ALU_ADD;
    w_dec_a_sel  = 1'b0;
    w_dec_b_sel  = 2'd0;
    w_dec_cmp_u  = 1'b0;
    w_dec_sr_ar  = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        case (w_fn)
          FN_SLL:          begin w_dec_alu_op = ALU_SL; w_dec_a_sel = 1'b1; end
          FN_SRL:          begin w_dec_alu_op = ALU_SR; w_dec_a_sel = 1'b1; end
          FN_SRA:          begin w_dec_alu_op = ALU_SR; w_dec_a_sel = 1'b1; w_dec_sr_ar = 1'b1; end
          FN_SLLV:         w_dec_alu_op = ALU_SL;
          FN_SRLV:         w_dec_alu_op = ALU_SR;
          FN_SRAV:         begin w_dec_alu_op = ALU_SR; w_dec_sr_ar = 1'b1; end
          FN_JR:           w_dec_alu_op = ALU_ADD;
          FN_ADD, FN_ADDU: w_dec_alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: w_dec_alu_op = ALU_SUB;
          FN_AND:          w_dec_alu_op = ALU_AND;
          FN_OR:           w_dec_alu_op = ALU_OR;
          FN_XOR:          w_dec_alu_op = ALU_XOR;
          FN_NOR:          w_dec_alu_op = ALU_NOR;
          FN_SLT:          w_dec_alu_op = ALU_CMP;
          FN_SLTU:         begin w_dec_alu_op = ALU_CMP; w_dec_cmp_u = 1'b1; end
          default:         w_legal = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_LUI: w_dec_alu_op = ALU_ADD;
      OP_BEQ, OP_BNE:       w_dec_alu_op = ALU_SUB;
      OP_ADDI, OP_ADDIU,
      OP_LW, OP_SW:         w_dec_b_sel = 2'd1;
      OP_SLTI:              begin w_dec_alu_op = ALU_CMP; w_dec_b_sel = 2'd1; end
      OP_SLTIU:             begin w_dec_alu_op = ALU_CMP; w_dec_b_sel = 2'd1; w_dec_cmp_u = 1'b1; end
      OP_ORI:               begin w_dec_alu_op = ALU_OR;  w_dec_b_sel = 2'd2; end
      OP_XORI:              begin w_dec_alu_op = ALU_XOR; w_dec_b_sel = 2'd2; end
      default:              w_legal = 1'b0;
    endcase
  end

  // Next-state and per-state control outputs.
  always_comb begin
    w_state_next   = r_state;
    w_set_illegal  = 1'b0;
    w_set_timeout  = 1'b0;
    w_mem_req      = 1'b0;
    w_mem_we       = 1'b0;
    w_addr_sel     = 1'b0;
    w_ir_we        = 1'b0;
    w_pc_we        = 1'b0;
    w_pc_src       = 2'd0;
    w_alu_op       = 4'd0;
    w_alu_a_sel    = 1'b0;
    w_alu_b_sel    = 2'd0;
    w_cmp_unsigned = 1'b0;
    w_sr_arith     = 1'b0;
    w_reg_we       = 1'b0;
    w_reg_dst      = 2'd0;
    w_wb_sel       = 2'd0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (bus.mem_ready) begin
          w_ir_we      = 1'b1;
          w_pc_we      = 1'b1;
          w_state_next = S_DECODE;
        end else if (w_expired) begin
          w_set_timeout = 1'b1;
          w_state_next  = S_HALT;
        end
      end
      S_DECODE: begin
        if (!w_legal) begin
          w_set_illegal = 1'b1;
          w_state_next  = S_HALT;
        end else if (w_is_j) begin
          w_pc_we      = 1'b1;
          w_pc_src     = 2'd2;
          w_state_next = S_FETCH;
        end else if (w_is_jal) begin
          // Link value is the PC before this write, which already holds PC+4.
          w_pc_we      = 1'b1;
          w_pc_src     = 2'd2;
          w_reg_we     = 1'b1;
          w_reg_dst    = 2'd2;
          w_wb_sel     = 2'd2;
          w_state_next = S_FETCH;
        end else if (w_is_jr) begin
          w_pc_we      = 1'b1;
          w_pc_src     = 2'd3;
          w_state_next = S_FETCH;
        end else begin
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_alu_op       = w_dec_alu_op;
        w_alu_a_sel    = w_dec_a_sel;
        w_alu_b_sel    = w_dec_b_sel;
        w_cmp_unsigned = w_dec_cmp_u;
        w_sr_arith     = w_dec_sr_ar;
        if (w_is_beq || w_is_bne) begin
          w_pc_src     = 2'd1;
          w_pc_we      = w_is_beq ? bus.alu_zero : !bus.alu_zero;
          w_state_next = S_FETCH;
        end else if (w_is_lw || w_is_sw) begin
          w_state_next = S_MEM;
        end else begin
          w_state_next = S_WB;
        end
      end
      S_MEM: begin
        w_mem_req  = 1'b1;
        w_addr_sel = 1'b1;
        w_mem_we   = w_is_sw;
        if (bus.mem_ready) begin
          w_state_next = w_is_sw ? S_FETCH : S_WB;
        end else if (w_expired) begin
          w_set_timeout = 1'b1;
          w_state_next  = S_HALT;
        end
      end
      S_WB: begin
        w_alu_op       = w_dec_alu_op;
        w_alu_a_sel    = w_dec_a_sel;
        w_alu_b_sel    = w_dec_b_sel;
        w_cmp_unsigned = w_dec_cmp_u;
        w_sr_arith     = w_dec_sr_ar;
        w_reg_we       = 1'b1;
        w_reg_dst      = w_is_rtype ? 2'd1 : 2'd0;
        w_wb_sel       = w_is_lw ? 2'd1 : (w_is_lui ? 2'd3 : 2'd0);
        w_state_next   = S_FETCH;
      end
      S_HALT: w_state_next = S_HALT;
      default: w_state_next = S_FETCH;
    endcase
  end

  // State, wait counter (cleared on each state entry) and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state) begin
        r_cnt <= '0;
      end else if (w_waiting) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_set_timeout) r_timeout <= 1'b1;
    end
  end

  // Strobes are gated by reset so an aborted instruction has no side effects.
  assign bus.mem_req      = w_mem_req & ~rst;
  assign bus.mem_we       = w_mem_we  & ~rst;
  assign bus.ir_we        = w_ir_we   & ~rst;
  assign bus.pc_we        = w_pc_we   & ~rst;
  assign bus.reg_we       = w_reg_we  & ~rst;
  assign bus.addr_sel     = w_addr_sel;
  assign bus.pc_src       = w_pc_src;
  assign bus.alu_op       = w_alu_op;
  assign bus.alu_a_sel    = w_alu_a_sel;
  assign bus.alu_b_sel    = w_alu_b_sel;
  assign bus.cmp_unsigned = w_cmp_unsigned;
  assign bus.sr_arith     = w_sr_arith;
  assign bus.reg_dst      = w_reg_dst;
  assign bus.wb_sel       = w_wb_sel;
  assign bus.state        = r_state;
  assign bus.illegal      = r_illegal;
  assign bus.timeout      = r_timeout;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: an instruction table drives a cycle-by-cycle
// expectation builder, then hand sequences and random traffic.
module tb_mips_mc_ctrl;

  localparam int K_R = 0, K_I = 1, K_LUI = 2, K_LW = 3, K_SW = 4;
  localparam int K_BEQ = 5, K_BNE = 6, K_J = 7, K_JAL = 8, K_JR = 9;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req, mem_we, addr_sel, ir_we, pc_we;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
    logic       alu_a_sel;
    logic [1:0] alu_b_sel;
    logic       cmp_unsigned, sr_arith, reg_we;
    logic [1:0] reg_dst, wb_sel;
    logic       illegal, timeout;
  } ctl_t;

  typedef struct {
    string      nm;
    logic [5:0] op;
    logic [5:0] fn;
    int         kind;
    logic [3:0] alu;
    logic       a;
    logic [1:0] b;
    logic       cu;
    logic       sa;
  } ent_t;

  typedef struct {
    logic mr;
    ctl_t exp;
  } step_t;

  logic        clk = 1'b0;
  logic        rst, rst4;
  logic [31:0] instr;
  logic        alu_zero, mem_ready;
  int          n_tests = 0;
  int          n_fail  = 0;
  ent_t        tbl[$];
  step_t       q[$];

  always #5 clk = ~clk;

  mips_mc_ctrl_if bif();
  mips_mc_ctrl_if bif4();
  assign bif.instr      = instr;
  assign bif.alu_zero   = alu_zero;
  assign bif.mem_ready  = mem_ready;
  assign bif4.instr     = instr;
  assign bif4.alu_zero  = alu_zero;
  assign bif4.mem_ready = mem_ready;

  mips_mc_ctrl dut (.clk(clk), .rst(rst), .bus(bif));
  mips_mc_ctrl #(.TIMEOUT(4)) dut4 (.clk(clk), .rst(rst4), .bus(bif4));

  function automatic ctl_t obs(input bit which);
    ctl_t c;
    if (which)
      c = {bif4.state, bif4.mem_req, bif4.mem_we, bif4.addr_sel, bif4.ir_we, bif4.pc_we,
           bif4.pc_src, bif4.alu_op, bif4.alu_a_sel, bif4.alu_b_sel, bif4.cmp_unsigned,
           bif4.sr_arith, bif4.reg_we, bif4.reg_dst, bif4.wb_sel, bif4.illegal, bif4.timeout};
    else
      c = {bif.state, bif.mem_req, bif.mem_we, bif.addr_sel, bif.ir_we, bif.pc_we,
           bif.pc_src, bif.alu_op, bif.alu_a_sel, bif.alu_b_sel, bif.cmp_unsigned,
           bif.sr_arith, bif.reg_we, bif.reg_dst, bif.wb_sel, bif.illegal, bif.timeout};
    return c;
  endfunction

  function automatic ctl_t blank(input int st);
    ctl_t c;
    c = '0;
    c.state = 3'(st);
    return c;
  endfunction

  function automatic ctl_t with_alu(input ctl_t c0, input ent_t e);
    ctl_t c;
    c = c0;
    c.alu_op = e.alu;
    c.alu_a_sel = e.a;
    c.alu_b_sel = e.b;
    c.cmp_unsigned = e.cu;
    c.sr_arith = e.sa;
    return c;
  endfunction

  task automatic chk(input string name, input ctl_t got, input ctl_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h (state %0d) expected %h (state %0d)",
               name, $time, got, got.state, exp, exp.state);
    end
  endtask

  task automatic push(input logic mr, input ctl_t c);
    step_t s;
    s.mr = mr;
    s.exp = c;
    q.push_back(s);
  endtask

  // Every step starts 1 time unit after a rising edge and compares mid-cycle.
  task automatic run_q(input string name, input bit which);
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      mem_ready = s.mr;
      #4;
      chk(name, obs(which), s.exp);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input bit which);
    if (which) rst4 = 1'b1; else rst = 1'b1;
    #4;
    chk("reset", obs(which), blank(0));
    @(posedge clk);
    #1;
    if (which) rst4 = 1'b0; else rst = 1'b0;
  endtask

  task automatic add(input string nm, input logic [5:0] op, input logic [5:0] fn, input int k,
                     input logic [3:0] alu, input logic a, input logic [1:0] b,
                     input logic cu, input logic sa);
    ent_t e;
    e.nm = nm; e.op = op; e.fn = fn; e.kind = k;
    e.alu = alu; e.a = a; e.b = b; e.cu = cu; e.sa = sa;
    tbl.push_back(e);
  endtask

  function automatic int find(input logic [31:0] x);
    foreach (tbl[i])
      if (tbl[i].op == x[31:26] && (x[31:26] != 6'd0 || tbl[i].fn == x[5:0])) return i;
    return -1;
  endfunction

  function automatic logic [31:0] mk(input ent_t e);
    logic [31:0] r;
    r = $urandom;
    r[31:26] = e.op;
    if (e.op == 6'd0) r[5:0] = e.fn;
    return r;
  endfunction

  task automatic model_fetch(input int fw);
    ctl_t c;
    c = blank(0);
    c.mem_req = 1'b1;
    repeat (fw) push(1'b0, c);
    c.ir_we = 1'b1;
    c.pc_we = 1'b1;
    push(1'b1, c);
  endtask

  // Expected cycle sequence of one instruction, from its class in the table.
  task automatic model_instr(input ent_t e, input logic az, input int fw, input int mw);
    ctl_t c;
    model_fetch(fw);
    c = blank(1);
    if (e.kind == K_J || e.kind == K_JAL || e.kind == K_JR) begin
      c.pc_we = 1'b1;
      c.pc_src = (e.kind == K_JR) ? 2'd3 : 2'd2;
      if (e.kind == K_JAL) begin
        c.reg_we = 1'b1;
        c.reg_dst = 2'd2;
        c.wb_sel = 2'd2;
      end
      push(1'($urandom), c);
      return;
    end
    push(1'($urandom), c);
    c = with_alu(blank(2), e);
    if (e.kind == K_BEQ || e.kind == K_BNE) begin
      c.alu_op = 4'd1;
      c.alu_b_sel = 2'd0;
      c.pc_src = 2'd1;
      c.pc_we = (e.kind == K_BEQ) ? az : !az;
      push(1'($urandom), c);
      return;
    end
    push(1'($urandom), c);
    if (e.kind == K_LW || e.kind == K_SW) begin
      c = blank(3);
      c.mem_req = 1'b1;
      c.addr_sel = 1'b1;
      c.mem_we = (e.kind == K_SW);
      repeat (mw) push(1'b0, c);
      push(1'b1, c);
      if (e.kind == K_SW) return;
    end
    c = with_alu(blank(4), e);
    c.reg_we = 1'b1;
    c.reg_dst = (e.kind == K_R) ? 2'd1 : 2'd0;
    c.wb_sel = (e.kind == K_LW) ? 2'd1 : ((e.kind == K_LUI) ? 2'd3 : 2'd0);
    push(1'($urandom), c);
  endtask

  task automatic model_illegal(input int fw);
    ctl_t c;
    model_fetch(fw);
    push(1'($urandom), blank(1));
    c = blank(5);
    c.illegal = 1'b1;
    push(1'($urandom), c);
    push(1'($urandom), c);
  endtask

  task automatic model_fetch_timeout(input int n);
    ctl_t c;
    c = blank(0);
    c.mem_req = 1'b1;
    repeat (n) push(1'b0, c);
    c = blank(5);
    c.timeout = 1'b1;
    push(1'b0, c);
    push(1'b1, c);
  endtask

  initial begin
    int idx;
    ctl_t c;
    rst = 1'b1; rst4 = 1'b1;
    instr = '0; alu_zero = 1'b0; mem_ready = 1'b0;

    add("SLL",  6'h00, 6'h00, K_R,   4'd7, 1, 2'd0, 0, 0);
    add("SRL",  6'h00, 6'h02, K_R,   4'd8, 1, 2'd0, 0, 0);
    add("SRA",  6'h00, 6'h03, K_R,   4'd8, 1, 2'd0, 0, 1);
    add("SLLV", 6'h00, 6'h04, K_R,   4'd7, 0, 2'd0, 0, 0);
    add("SRLV", 6'h00, 6'h06, K_R,   4'd8, 0, 2'd0, 0, 0);
    add("SRAV", 6'h00, 6'h07, K_R,   4'd8, 0, 2'd0, 0, 1);
    add("JR",   6'h00, 6'h08, K_JR,  4'd0, 0, 2'd0, 0, 0);
    add("ADD",  6'h00, 6'h20, K_R,   4'd0, 0, 2'd0, 0, 0);
    add("ADDU", 6'h00, 6'h21, K_R,   4'd0, 0, 2'd0, 0, 0);
    add("SUB",  6'h00, 6'h22, K_R,   4'd1, 0, 2'd0, 0, 0);
    add("SUBU", 6'h00, 6'h23, K_R,   4'd1, 0, 2'd0, 0, 0);
    add("AND",  6'h00, 6'h24, K_R,   4'd3, 0, 2'd0, 0, 0);
    add("OR",   6'h00, 6'h25, K_R,   4'd4, 0, 2'd0, 0, 0);
    add("XOR",  6'h00, 6'h26, K_R,   4'd5, 0, 2'd0, 0, 0);
    add("NOR",  6'h00, 6'h27, K_R,   4'd6, 0, 2'd0, 0, 0);
    add("SLT",  6'h00, 6'h2A, K_R,   4'd2, 0, 2'd0, 0, 0);
    add("SLTU", 6'h00, 6'h2B, K_R,   4'd2, 0, 2'd0, 1, 0);
    add("J",    6'h02, 6'h00, K_J,   4'd0, 0, 2'd0, 0, 0);
    add("JAL",  6'h03, 6'h00, K_JAL, 4'd0, 0, 2'd0, 0, 0);
    add("BEQ",  6'h04, 6'h00, K_BEQ, 4'd1, 0, 2'd0, 0, 0);
    add("BNE",  6'h05, 6'h00, K_BNE, 4'd1, 0, 2'd0, 0, 0);
    add("ADDI", 6'h08, 6'h00, K_I,   4'd0, 0, 2'd1, 0, 0);
    add("ADDIU",6'h09, 6'h00, K_I,   4'd0, 0, 2'd1, 0, 0);
    add("SLTI", 6'h0A, 6'h00, K_I,   4'd2, 0, 2'd1, 0, 0);
    add("SLTIU",6'h0B, 6'h00, K_I,   4'd2, 0, 2'd1, 1, 0);
    add("ORI",  6'h0D, 6'h00, K_I,   4'd4, 0, 2'd2, 0, 0);
    add("XORI", 6'h0E, 6'h00, K_I,   4'd5, 0, 2'd2, 0, 0);
    add("LUI",  6'h0F, 6'h00, K_LUI, 4'd0, 0, 2'd0, 0, 0);
    add("LW",   6'h23, 6'h00, K_LW,  4'd0, 0, 2'd1, 0, 0);
    add("SW",   6'h2B, 6'h00, K_SW,  4'd0, 0, 2'd1, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    do_reset(0);

    // Every table entry once, no waits.
    foreach (tbl[i]) begin
      instr = mk(tbl[i]);
      alu_zero = 1'($urandom);
      model_instr(tbl[i], alu_zero, 0, 0);
      run_q(tbl[i].nm, 0);
    end

    // Branch resolution both ways.
    for (int z = 1; z >= 0; z--) begin
      for (int k = K_BEQ; k <= K_BNE; k++) begin
        idx = (k == K_BEQ) ? 19 : 20;
        instr = mk(tbl[idx]);
        alu_zero = 1'(z);
        model_instr(tbl[idx], alu_zero, 0, 0);
        run_q((k == K_BEQ) ? "beq_zero" : "bne_zero", 0);
      end
    end

    // Load with three memory wait cycles, store with two.
    instr = mk(tbl[28]);
    model_instr(tbl[28], 1'b0, 1, 3);
    run_q("lw_waits", 0);
    instr = mk(tbl[29]);
    model_instr(tbl[29], 1'b0, 2, 2);
    run_q("sw_waits", 0);

    // Longest legal fetch wait with the default limit, then one cycle more.
    instr = mk(tbl[8]);
    model_instr(tbl[8], 1'b0, 254, 0);
    run_q("fetch_wait_254", 0);
    model_fetch_timeout(255);
    run_q("fetch_timeout_255", 0);
    do_reset(0);

    // Reset in the middle of a load aborts it.
    instr = mk(tbl[28]);
    model_fetch(0);
    push(1'b0, blank(1));
    run_q("abort_prefix", 0);
    rst = 1'b1;
    #1;
    chk("rst_abort", obs(0), blank(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    instr = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
    model_instr(tbl[8], 1'b0, 0, 0);
    run_q("addu_after_abort", 0);

    // ANDI is not supported.
    instr = {6'b001100, 26'h0012345};
    model_illegal(0);
    run_q("andi_illegal", 0);
    do_reset(0);

    // Random traffic.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do instr = $urandom; while (find(instr) >= 0);
        model_illegal($urandom_range(0, 2));
        run_q("rand_illegal", 0);
        do_reset(0);
      end else begin
        idx = $urandom_range(0, tbl.size() - 1);
        instr = mk(tbl[idx]);
        alu_zero = 1'($urandom);
        model_instr(tbl[idx], alu_zero, $urandom_range(0, 3), $urandom_range(0, 3));
        run_q(tbl[idx].nm, 0);
      end
    end

    // Short-limit instance: fetch stuck, fetch ready on the 4th cycle, load stuck.
    do_reset(1);
    model_fetch_timeout(4);
    run_q("t4_fetch_timeout", 1);
    do_reset(1);
    instr = mk(tbl[8]);
    model_instr(tbl[8], 1'b0, 3, 0);
    run_q("t4_fetch_ready_4th", 1);
    instr = mk(tbl[28]);
    model_instr(tbl[28], 1'b0, 0, 3);
    run_q("t4_mem_ready_4th", 1);
    model_fetch(0);
    push(1'b0, blank(1));
    push(1'b0, with_alu(blank(2), tbl[28]));
    c = blank(3);
    c.mem_req = 1'b1;
    c.addr_sel = 1'b1;
    repeat (4) push(1'b0, c);
    c = blank(5);
    c.timeout = 1'b1;
    push(1'b1, c);
    run_q("t4_mem_timeout", 1);
    do_reset(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: cycles to wait for mem_ready in FETCH/MEM before halting; 0 disables the timeout.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 instr  in  32  current instruction register contents.
REQ-005 alu_zero  in  1  ALU result == 0.
REQ-006 mem_ready  in  1  memory completes the current request this cycle.
REQ-007 mem_req / mem_we  out  1/1  memory request / write qualifier.
REQ-008 addr_sel  out  1  memory address source: 0 = PC, 1 = latched ALU result.
REQ-009 ir_we / pc_we  out  1/1  instruction register / PC write strobes.
REQ-010 pc_src  out  2  next PC: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs.
REQ-011 alu_op  out  4  ALU operation: ADD=0, SUB=1, CMP=2, AND=3, OR=4, XOR=5, NOR=6, SL=7, SR=8.
REQ-012 alu_a_sel  out  1  ALU A input: 0 = rs, 1 = shamt.
REQ-013 alu_b_sel  out  2  ALU B input: 0 = rt, 1 = sign-extended imm, 2 = zero-extended imm, 3 = constant 4.
REQ-014 cmp_unsigned / sr_arith  out  1/1  unsigned compare / arithmetic right shift.
REQ-015 reg_we  out  1  register file write strobe.
REQ-016 reg_dst  out  2  destination register: 0 = rt, 1 = rd, 2 = r31.
REQ-017 wb_sel  out  2  write-back data: 0 = ALU, 1 = memory data, 2 = PC (link), 3 = imm<<16.
REQ-018 state  out  3  FSM state (debug): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-019 illegal / timeout  out  1/1  sticky error flags.

Function
REQ-020 The state register is clocked; all other outputs are combinational from state, instr, mem_ready and alu_zero; unlisted strobes are 0 and unlisted selects are 0.
REQ-021 FETCH: mem_req=1, addr_sel=0; holds while mem_ready=0; on mem_ready=1: ir_we=1, pc_we=1, pc_src=0, next state DECODE.
REQ-022 DECODE, J: pc_we=1, pc_src=2 -> FETCH.
REQ-023 DECODE, JAL: pc_we=1, pc_src=2, reg_we=1, reg_dst=2, wb_sel=2 (datapath writes the pre-update PC value, i.e. PC+4) -> FETCH.
REQ-024 DECODE, JR (RTYPE with func 001000): pc_we=1, pc_src=3 -> FETCH.
REQ-025 DECODE, any opcode or RTYPE func outside the supported set: illegal set to 1 -> HALT; all other instructions -> EXEC.
REQ-026 ALU decode: ADD/ADDU/ADDI/ADDIU/LW/SW -> ADD; SUB/SUBU -> SUB; SLT/SLTI -> CMP with cmp_unsigned=0; SLTU/SLTIU -> CMP with cmp_unsigned=1; AND, NOR as named; OR/ORI -> OR; XOR/XORI -> XOR; SLL/SLLV -> SL; SRL/SRLV -> SR with sr_arith=0; SRA/SRAV -> SR with sr_arith=1.
REQ-027 Operand selects: SLL/SRL/SRA use alu_a_sel=1; ADDI/ADDIU/SLTI/SLTIU/LW/SW use alu_b_sel=1; ORI/XORI use alu_b_sel=2; other R-type uses alu_b_sel=0; arithmetic overflow never traps.
REQ-028 EXEC, BEQ/BNE: alu_op=SUB, alu_b_sel=0, pc_src=1; pc_we = alu_zero for BEQ, !alu_zero for BNE -> FETCH.
REQ-029 EXEC, LW/SW -> MEM; all other instructions -> WB; the datapath latches the ALU result every cycle.
REQ-030 MEM: mem_req=1, addr_sel=1, mem_we=1 for SW; holds until mem_ready=1; then SW -> FETCH, LW -> WB (datapath latches read data).
REQ-031 WB: reg_we=1; reg_dst=1 for RTYPE, else 0; wb_sel=1 for LW, 3 for LUI, else 0; ALU controls are held at their EXEC values -> FETCH.
REQ-032 LUI passes through EXEC with no ALU dependence and takes 4 cycles; R-type/immediate = 4, LW = 5 + memory waits, SW = 4 + waits, branch = 3, jump = 2 (plus FETCH waits).
REQ-033 Timeout counter: clears on every state entry and counts cycles in FETCH/MEM with mem_ready=0; on reaching TIMEOUT (when nonzero) timeout is set to 1 -> HALT; mem_ready on the same cycle takes priority.
REQ-034 HALT: all strobes 0, mem_req=0; left only by reset.

Reset
REQ-035 While rst=1: state=FETCH, counter=0, illegal=0, timeout=0, and all strobes (mem_req, mem_we, ir_we, pc_we, reg_we) are forced to 0 combinationally; rst asserted mid-instruction aborts it immediately.
REQ-036 The first cycle after rst deasserts is FETCH with mem_req=1.

Verification
REQ-037 ADDU $3,$1,$2 with mem_ready=1 -> states 0,1,2,4,0; in WB: reg_we=1, reg_dst=1, alu_op=0, wb_sel=0.
REQ-038 LW with mem_ready held 0 for 3 MEM cycles -> MEM lasts 4 cycles with addr_sel=1, mem_we=0; then WB with wb_sel=1, reg_dst=0.
REQ-039 BEQ with alu_zero=1, then BNE with alu_zero=1 -> pc_we=1 for BEQ and pc_we=0 for BNE, pc_src=1 in both cases.
REQ-040 JAL -> in DECODE: pc_we=1, pc_src=2, reg_we=1, reg_dst=2, wb_sel=2; next state FETCH.
REQ-041 Opcode 6'b001100 (ANDI) -> illegal=1, state=5, all strobes 0; pulse rst -> state=0, illegal=0.
REQ-042 TIMEOUT=4 and mem_ready stuck 0 in FETCH -> timeout=1, state=5 after 4 cycles; a separate run with mem_ready=1 on the 4th cycle -> DECODE with no timeout.
